// File: rtl/buzzer_note_scheduler_if.sv
// buzzer_note_scheduler_if: song player note stream handshake (valid/ready).
interface buzzer_note_scheduler_if #(parameter int NOTE_W = 4);
  logic valid;
  logic [NOTE_W-1:0] note;
  logic ready;
  modport master (output valid, output note, input ready);
  modport slave (input valid, input note, output ready);
endinterface

// File: rtl/buzzer_note_scheduler.sv
// buzzer_note_scheduler: arbitrates piano keys over a song stream for the shared buzzer counter,
// issues start pulses, detects note end via iRing and inserts the inter-note gap.
module buzzer_note_scheduler #(
  parameter int NUM_KEYS = 8,
  parameter int NOTE_W = 4,
  parameter int GAP_CYCLES = 5000,
  parameter int REST_CYCLES = 150000,
  parameter int WD_CYCLES = 4
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic [NUM_KEYS-1:0] iKeys,
  buzzer_note_scheduler_if.slave song,
  input  logic iRing,
  output logic oCountEnable,
  output logic [NOTE_W-1:0] oNote,
  output logic oSrcKey,
  output logic oBusy,
  output logic oFault
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = REST_CYCLES > 1 ? $clog2(REST_CYCLES) : 1;
  localparam int WW = WD_CYCLES > 1 ? $clog2(WD_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [RW-1:0] REST_LAST = RW'(REST_CYCLES > 0 ? REST_CYCLES - 1 : 0);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES > 0 ? WD_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, PLAY, REST, GAP} state_t;
  state_t state, stateNext;
  logic [NUM_KEYS-1:0] kPrev, kEdge;
  logic [NOTE_W-1:0] keyNote;
  logic [GW-1:0] gapCnt;
  logic [RW-1:0] restCnt;
  logic [WW-1:0] wdCnt;
  logic ringSeen, keyHit, songTake, ringNow, ringEnd, wdExpire, enter;
  assign kEdge = iKeys & ~kPrev;
  assign keyHit = |kEdge;
  assign song.ready = state == IDLE && !keyHit;
  assign songTake = song.ready && song.valid;
  assign oBusy = state != IDLE;
  assign ringNow = ringSeen | iRing;
  assign ringEnd = ringSeen & ~iRing;
  assign wdExpire = !ringNow && wdCnt == WD_LAST;
  assign enter = keyHit || stateNext != state;
  // Descending scan leaves the lowest pressed index as the winner.
  always_comb begin
    keyNote = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (kEdge[i]) keyNote = NOTE_W'(i + 1);
  end
  always_comb begin
    stateNext = state;
    if (keyHit) stateNext = PLAY;
    else if (songTake) stateNext = |song.note ? PLAY : REST;
    else if (state == PLAY) stateNext = ringEnd ? GAP : wdExpire ? IDLE : PLAY;
    else if (state == REST && restCnt == REST_LAST) stateNext = GAP;
    else if (state == GAP && gapCnt == GAP_LAST) stateNext = IDLE;
  end
  always_ff @(posedge iClk) state <= !iReset_n ? IDLE : stateNext;
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      kPrev <= '0;
      oCountEnable <= 1'b0;
      oNote <= '0;
      oSrcKey <= 1'b0;
      oFault <= 1'b0;
      ringSeen <= 1'b0;
      wdCnt <= '0;
      restCnt <= '0;
      gapCnt <= '0;
    end else begin
      kPrev <= iKeys;
      oCountEnable <= keyHit || (songTake && |song.note);
      if (keyHit) begin
        oNote <= keyNote;
        oSrcKey <= 1'b1;
      end else if (songTake) begin
        oNote <= song.note;
        oSrcKey <= 1'b0;
      end else if (state == PLAY && stateNext != PLAY) oNote <= '0;
      oFault <= oFault || (state == PLAY && !keyHit && wdExpire);
      ringSeen <= !enter && state == PLAY && ringNow;
      wdCnt <= (enter || state != PLAY || ringNow) ? '0 : wdCnt + 1'b1;
      restCnt <= (enter || state != REST) ? '0 : restCnt + 1'b1;
      gapCnt <= (enter || state != GAP) ? '0 : gapCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_buzzer_note_scheduler.sv
// tb_buzzer_note_scheduler: directed checks of key/song arbitration, gap, rest and watchdog
// against a 20-cycle buzzer duration counter model.
module tb_buzzer_note_scheduler;
  localparam int NOTE_W = 4;
  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  logic [7:0] iKeys = '0;
  logic iRing;
  logic oCountEnable, oSrcKey, oBusy, oFault;
  logic [NOTE_W-1:0] oNote;
  logic tieOff = 1'b0;
  logic [5:0] ringCnt;
  int nCmp = 0;
  int nErr = 0;
  int pulses;
  buzzer_note_scheduler_if #(.NOTE_W(NOTE_W)) song ();
  buzzer_note_scheduler #(
    .NUM_KEYS(8), .NOTE_W(NOTE_W), .GAP_CYCLES(10), .REST_CYCLES(16), .WD_CYCLES(4)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iKeys(iKeys), .song(song), .iRing(iRing),
    .oCountEnable(oCountEnable), .oNote(oNote), .oSrcKey(oSrcKey), .oBusy(oBusy), .oFault(oFault)
  );
  always #5 iClk = ~iClk;
  always @(posedge iClk)
    if (!iReset_n) ringCnt <= '0;
    else if (oCountEnable) ringCnt <= 6'd20;
    else if (ringCnt != 0) ringCnt <= ringCnt - 6'd1;
  assign iRing = !tieOff && ringCnt != 0;
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge iClk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    song.valid = 1'b0;
    song.note = '0;
    cyc(3);
    check("rst_ce", oCountEnable, 0);
    check("rst_note", oNote, 0);
    check("rst_src", oSrcKey, 0);
    check("rst_fault", oFault, 0);
    check("rst_busy", oBusy, 0);
    iReset_n = 1'b1;
    cyc();
    check("idle_ready", song.ready, 1);
    check("idle_busy", oBusy, 0);
    // key 3 press, 20-cycle ring, 10-cycle gap
    iKeys = 8'h08;
    cyc();
    check("k3_note", oNote, 4);
    check("k3_src", oSrcKey, 1);
    check("k3_ce", oCountEnable, 1);
    check("k3_busy", oBusy, 1);
    cyc();
    check("k3_ce_drop", oCountEnable, 0);
    cyc(20);
    check("k3_note_last", oNote, 4);
    cyc();
    check("k3_gap_note", oNote, 0);
    check("k3_gap_busy", oBusy, 1);
    cyc(9);
    check("k3_gap_end_busy", oBusy, 1);
    cyc();
    check("k3_idle_busy", oBusy, 0);
    check("k3_idle_ready", song.ready, 1);
    // key 0 and song note 5 offered together
    iKeys = 8'h01;
    song.valid = 1'b1;
    song.note = 4'd5;
    #1;
    check("tie_ready", song.ready, 0);
    cyc();
    check("tie_note", oNote, 1);
    check("tie_src", oSrcKey, 1);
    check("tie_ready_play", song.ready, 0);
    cyc(21);
    check("tie_note_last", oNote, 1);
    cyc();
    check("tie_gap_note", oNote, 0);
    cyc(10);
    check("tie_idle_ready", song.ready, 1);
    cyc();
    check("song5_note", oNote, 5);
    check("song5_src", oSrcKey, 0);
    check("song5_ce", oCountEnable, 1);
    song.valid = 1'b0;
    cyc(32);
    check("song5_idle", oBusy, 0);
    // song note 7 pre-empted by key 2 on ring cycle 10
    song.valid = 1'b1;
    song.note = 4'd7;
    #1;
    check("song7_ready", song.ready, 1);
    cyc();
    check("song7_note", oNote, 7);
    check("song7_ce", oCountEnable, 1);
    song.valid = 1'b0;
    cyc(10);
    check("song7_ring", iRing, 1);
    iKeys = 8'h05;
    cyc();
    check("pre_note", oNote, 3);
    check("pre_ce", oCountEnable, 1);
    check("pre_src", oSrcKey, 1);
    cyc();
    check("pre_ce_drop", oCountEnable, 0);
    cyc(20);
    check("pre_note_last", oNote, 3);
    cyc();
    check("pre_gap_note", oNote, 0);
    cyc(10);
    check("pre_idle", oBusy, 0);
    // held key gives a single pulse
    iKeys = 8'h00;
    cyc();
    iKeys = 8'h01;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      pulses += int'(oCountEnable);
    end
    check("held_pulses", pulses, 1);
    check("held_busy", oBusy, 0);
    iKeys = 8'h00;
    cyc();
    iKeys = 8'h01;
    cyc();
    check("repress_ce", oCountEnable, 1);
    check("repress_note", oNote, 1);
    cyc(32);
    check("repress_idle", oBusy, 0);
    // song rest: 16 rest cycles then 10 gap cycles
    song.valid = 1'b1;
    song.note = 4'd0;
    cyc();
    song.valid = 1'b0;
    check("rest_busy", oBusy, 1);
    check("rest_note", oNote, 0);
    check("rest_ce", oCountEnable, 0);
    check("rest_ready", song.ready, 0);
    cyc(25);
    check("rest_gap_busy", oBusy, 1);
    cyc();
    check("rest_idle", oBusy, 0);
    // watchdog with ring tied off
    tieOff = 1'b1;
    iKeys = 8'h03;
    cyc();
    check("wd_note", oNote, 2);
    check("wd_ce", oCountEnable, 1);
    cyc(3);
    check("wd_fault_early", oFault, 0);
    check("wd_busy_early", oBusy, 1);
    cyc();
    check("wd_fault", oFault, 1);
    check("wd_note_off", oNote, 0);
    check("wd_idle", oBusy, 0);
    iKeys = 8'h07;
    cyc();
    check("wd_resume_note", oNote, 3);
    check("wd_sticky", oFault, 1);
    cyc();
    iReset_n = 1'b0;
    cyc();
    check("mid_rst_fault", oFault, 0);
    check("mid_rst_note", oNote, 0);
    check("mid_rst_busy", oBusy, 0);
    check("mid_rst_ce", oCountEnable, 0);
    iKeys = 8'h00;
    iReset_n = 1'b1;
    cyc();
    check("post_rst_ready", song.ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
